stream_mux_rr: RTL

//  Registered N-to-1 stream multiplexer. Parametrised, sequential successor of the 4:1 combinational mux.

---
 rtl/stream_mux_rr.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 valid/ready stream multiplexer with fixed-select and round-robin modes.
// One output register, one-cycle latency, full throughput when the consumer is always ready.

module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [SEL_W-1:0]         out_ch_o,
  input  logic                     out_ready_i
);

  localparam int PW = SEL_W + 1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic              load_en_s;
  logic              fix_vld_s;
  logic              rr_vld_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic              grant_vld_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [DATA_W-1:0] grant_data_s;
  logic              xfer_s;

  assign load_en_s = !out_valid_q || out_ready_i;

  // Fixed-mode grant: sel must name an existing channel that is offering data.
  always_comb begin
    fix_vld_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      fix_vld_s = fix_vld_s | ((sel_i == SEL_W'(i)) & in_valid_i[i]);
    end
  end

  // Round-robin scan starting just after the last granted channel; rr_ptr itself is visited last.
  always_comb begin
    logic [PW-1:0]    cand_w;
    logic [SEL_W-1:0] cand;
    rr_vld_s = 1'b0;
    rr_idx_s = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand_w = {1'b0, rr_ptr_q} + PW'(off);
      if (cand_w >= PW'(NUM_CH)) begin
        cand_w = cand_w - PW'(NUM_CH);
      end else begin
        cand_w = cand_w;
      end
      cand = cand_w[SEL_W-1:0];
      if (!rr_vld_s && in_valid_i[cand]) begin
        rr_vld_s = 1'b1;
        rr_idx_s = cand;
      end else begin
        rr_vld_s = rr_vld_s;
      end
    end
  end

  // Mode select between the two grant sources.
  always_comb begin
    if (mode_i) begin
      grant_vld_s = rr_vld_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_vld_s = fix_vld_s;
      grant_idx_s = sel_i;
    end
  end

  // Data mux driven only by the grant index, so in_ready never depends on data.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_data_s = grant_data_s |
                     ((grant_idx_s == SEL_W'(i)) ? in_data_i[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
  end

  // Gating with rst_n keeps every channel stalled while the block is held in reset.
  assign xfer_s = rst_n && load_en_s && grant_vld_s;

  // One-hot ready towards the granted channel.
  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready_o[i] = xfer_s && (grant_idx_s == SEL_W'(i));
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en_s) begin
      if (grant_vld_s) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data_s;
        out_ch_d    = grant_idx_s;
        rr_ptr_d    = mode_i ? grant_idx_s : rr_ptr_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; rr_ptr resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

  stream_mux_rr_chk #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_i  (in_ready_o),
    .out_valid_i (out_valid_q),
    .out_data_i  (out_data_q),
    .out_ch_i    (out_ch_q),
    .out_ready_i (out_ready_i)
  );

endmodule

// Protocol properties of the mux boundary: single grant, grant only to offering channels,
// and a stable output word while the consumer stalls.
module stream_mux_rr_chk #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic [NUM_CH-1:0] in_valid_i,
  input logic [NUM_CH-1:0] in_ready_i,
  input logic              out_valid_i,
  input logic [DATA_W-1:0] out_data_i,
  input logic [SEL_W-1:0]  out_ch_i,
  input logic              out_ready_i
);

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready_i))
    else $error("in_ready has more than one bit set");

  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready_i & ~in_valid_i) == '0)
    else $error("in_ready raised for a channel that is not valid");

  a_stall_no_ready : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_i && !out_ready_i) |-> (in_ready_i == '0))
    else $error("in_ready raised while output is stalled");

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_i && !out_ready_i) |=> (out_valid_i && $stable(out_data_i) && $stable(out_ch_i)))
    else $error("output word changed while stalled");

endmodule
